// File: rtl/dcache_evict.sv
// dcache_evict: line-eviction reader for the 4-way data cache.
//
// On an accepted start the victim tag/index/way are latched, then every word of the line is
// read through the data RAM's combinational port (one READ cycle per word), the victim way is
// selected and registered, and the word is offered to the memory write channel (SEND) under a
// valid/ready handshake together with its byte address {tag, index, offset, 2'b00}.
//
// Optional feature macro: DCACHE_EVICT_PARITY_EN adds o_mem_par, the XOR of o_mem_data,
// registered alongside the data.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start                      eviction request, sampled only in IDLE
//   i_ev_tag/i_ev_index/i_ev_way victim tag, set and way, captured on accepted start
//   o_busy                       high in READ, SEND and DONE
//   o_done                       one-cycle pulse after the last word is accepted
//   o_ram_index/o_ram_offset     data RAM read address (latched index, word counter)
//   o_ram_en                     data RAM enable, high only in READ
//   i_ram_dout0..i_ram_dout3     data RAM read data for ways 0-3
//   o_mem_valid/i_mem_ready      memory write channel handshake
//   o_mem_addr/o_mem_data        byte address and data of the offered word
//   o_mem_last                   marks the final word of the line
//   o_mem_par                    (parity build only) even parity of o_mem_data

`ifndef D_INDEX_WIDTH
`define D_INDEX_WIDTH 6
`endif
`ifndef D_WO_WIDTH
`define D_WO_WIDTH 3
`endif

module dcache_evict #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned IndexWidth  = `D_INDEX_WIDTH,
    parameter int unsigned OffsetWidth = `D_WO_WIDTH,
    parameter int unsigned TagWidth    = 20,
    localparam int unsigned AddrWidth  = TagWidth + IndexWidth + OffsetWidth + 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [TagWidth-1:0]    i_ev_tag,
    input  logic [IndexWidth-1:0]  i_ev_index,
    input  logic [1:0]             i_ev_way,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [IndexWidth-1:0]  o_ram_index,
    output logic [OffsetWidth-1:0] o_ram_offset,
    output logic                   o_ram_en,
    input  logic [DataWidth-1:0]   i_ram_dout0,
    input  logic [DataWidth-1:0]   i_ram_dout1,
    input  logic [DataWidth-1:0]   i_ram_dout2,
    input  logic [DataWidth-1:0]   i_ram_dout3,
    output logic                   o_mem_valid,
    input  logic                   i_mem_ready,
    output logic [AddrWidth-1:0]   o_mem_addr,
    output logic [DataWidth-1:0]   o_mem_data,
`ifdef DCACHE_EVICT_PARITY_EN
    output logic                   o_mem_par,
`endif
    output logic                   o_mem_last
);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [TagWidth-1:0]    r_tag;
    logic [IndexWidth-1:0]  r_index;
    logic [1:0]             r_way;
    logic [OffsetWidth-1:0] r_cnt;
    logic [DataWidth-1:0]   r_data;
    logic [DataWidth-1:0]   w_sel;
    logic                   w_cnt_last;

    // Counter is all ones on the final word; it never wraps inside a line.
    assign w_cnt_last = (r_cnt == {OffsetWidth{1'b1}});

    always_comb begin
        w_sel = '0;
        unique case (r_way)
            2'd0: w_sel = i_ram_dout0;
            2'd1: w_sel = i_ram_dout1;
            2'd2: w_sel = i_ram_dout2;
            2'd3: w_sel = i_ram_dout3;
            default: w_sel = '0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_start) w_state_next = StRead;
            StRead: w_state_next = StSend;
            StSend: begin
                if (i_mem_ready) begin
                    w_state_next = w_cnt_last ? StDone : StRead;
                end
            end
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from state (and the registered counter) only; i_mem_ready never
    // reaches an output combinationally.
    always_comb begin
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_ram_en    = 1'b0;
        o_mem_valid = 1'b0;
        o_mem_last  = 1'b0;
        unique case (r_state)
            StIdle: ;
            StRead: begin
                o_busy   = 1'b1;
                o_ram_en = 1'b1;
            end
            StSend: begin
                o_busy      = 1'b1;
                o_mem_valid = 1'b1;
                o_mem_last  = w_cnt_last;
            end
            StDone: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: latched victim, word counter and captured word. The counter only moves on a
    // handshake, so address and data stay put while the memory side stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag   <= '0;
            r_index <= '0;
            r_way   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_tag   <= i_ev_tag;
                        r_index <= i_ev_index;
                        r_way   <= i_ev_way;
                        r_cnt   <= '0;
                    end
                end
                StRead: r_data <= w_sel;
                StSend: begin
                    if (i_mem_ready && !w_cnt_last) begin
                        r_cnt <= r_cnt + OffsetWidth'(1);
                    end
                end
                StDone: ;
                default: ;
            endcase
        end
    end

`ifdef DCACHE_EVICT_PARITY_EN
    logic r_par;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_par <= 1'b0;
        end else if (r_state == StRead) begin
            r_par <= ^w_sel;
        end
    end

    assign o_mem_par = r_par;
`endif

    assign o_ram_index  = r_index;
    assign o_ram_offset = r_cnt;
    assign o_mem_addr   = {r_tag, r_index, r_cnt, 2'b00};
    assign o_mem_data   = r_data;

endmodule

// File: tb/tb_dcache_evict.sv
// Self-checking bench for dcache_evict. A per-line reference (expected word list built from
// the RAM contents, tag and index) is compared against every offered word; handshakes,
// stalls, stray starts and mid-line reset are driven with $urandom.

`ifndef D_INDEX_WIDTH
`define D_INDEX_WIDTH 6
`endif
`ifndef D_WO_WIDTH
`define D_WO_WIDTH 3
`endif

module tb_dcache_evict;

    localparam int TW = 20;
    localparam int IW = `D_INDEX_WIDTH;
    localparam int OW = `D_WO_WIDTH;
    localparam int AW = TW + IW + OW + 2;
    localparam int N  = 1 << OW;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [TW-1:0] i_ev_tag = '0;
    logic [IW-1:0] i_ev_index = '0;
    logic [1:0]    i_ev_way = '0;
    logic          o_busy, o_done, o_ram_en, o_mem_valid, o_mem_last;
    logic [IW-1:0] o_ram_index;
    logic [OW-1:0] o_ram_offset;
    logic [31:0]   w_dout0, w_dout1, w_dout2, w_dout3;
    logic          i_mem_ready = 1'b1;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_data;
`ifdef DCACHE_EVICT_PARITY_EN
    logic          o_mem_par;
`endif

    logic [31:0] ram_mem [4][N];

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    // RAM model: combinational read; junk when not enabled so mistimed captures show up.
    assign w_dout0 = o_ram_en ? ram_mem[0][o_ram_offset] : 32'hDEAD_BEEF;
    assign w_dout1 = o_ram_en ? ram_mem[1][o_ram_offset] : 32'hDEAD_BEEF;
    assign w_dout2 = o_ram_en ? ram_mem[2][o_ram_offset] : 32'hDEAD_BEEF;
    assign w_dout3 = o_ram_en ? ram_mem[3][o_ram_offset] : 32'hDEAD_BEEF;

    dcache_evict u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_ev_tag     (i_ev_tag),
        .i_ev_index   (i_ev_index),
        .i_ev_way     (i_ev_way),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_ram_index  (o_ram_index),
        .o_ram_offset (o_ram_offset),
        .o_ram_en     (o_ram_en),
        .i_ram_dout0  (w_dout0),
        .i_ram_dout1  (w_dout1),
        .i_ram_dout2  (w_dout2),
        .i_ram_dout3  (w_dout3),
        .o_mem_valid  (o_mem_valid),
        .i_mem_ready  (i_mem_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
`ifdef DCACHE_EVICT_PARITY_EN
        .o_mem_par    (o_mem_par),
`endif
        .o_mem_last   (o_mem_last)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_eq({pfx, "_busy"}, o_busy, 0);
        check_eq({pfx, "_done"}, o_done, 0);
        check_eq({pfx, "_ram_en"}, o_ram_en, 0);
        check_eq({pfx, "_ram_index"}, o_ram_index, 0);
        check_eq({pfx, "_ram_offset"}, o_ram_offset, 0);
        check_eq({pfx, "_mem_valid"}, o_mem_valid, 0);
        check_eq({pfx, "_mem_addr"}, o_mem_addr, 0);
        check_eq({pfx, "_mem_data"}, o_mem_data, 0);
        check_eq({pfx, "_mem_last"}, o_mem_last, 0);
`ifdef DCACHE_EVICT_PARITY_EN
        check_eq({pfx, "_mem_par"}, o_mem_par, 0);
`endif
    endtask

    // Fill the four ways with distinct patterns: way w words carry top byte 0xA0 + 0x10*w.
    task automatic fill_ram();
        for (int w = 0; w < 4; w++) begin
            for (int o = 0; o < N; o++) begin
                ram_mem[w][o] = {8'hA0 + 8'(w * 16), 24'($urandom)};
            end
        end
        // Known parity corner words.
        ram_mem[1][0] = 32'h0000_0001;
        ram_mem[1][1] = 32'h0000_0003;
    endtask

    // Run one eviction. stall_word/stall_len force ready low on one word; rand_ready adds
    // random stalls; pulse_word drives a stray start in SEND; rst_word resets mid-SEND.
    task automatic do_line(input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                           input logic [1:0] way, input int stall_word, input int stall_len,
                           input bit rand_ready, input int pulse_word, input int rst_word);
        int k = 0;
        int stalls = 0;
        int forced = 0;
        int dones = 0;
        int busy_cyc = 0;
        bit fin = 0;
        bit held = 0;
        bit done_seen = 0;
        bit pulsed = 0;
        logic [AW-1:0] p_addr, e_addr;
        logic [31:0]   p_data, e_data;
        logic          p_last;

        fill_ram();
        @(negedge i_clk);
        i_start     = 1'b1;
        i_ev_tag    = tag;
        i_ev_index  = idx;
        i_ev_way    = way;
        i_mem_ready = 1'b1;
        for (int cyc = 0; cyc < 20 * N + 20 && !fin; cyc++) begin
            @(negedge i_clk);
            i_start    = 1'b0;
            i_ev_tag   = TW'($urandom);
            i_ev_index = IW'($urandom);
            i_ev_way   = 2'($urandom);
            if (cyc == 0) check_eq("lat_read", o_ram_en, 1);
            if (cyc == 1) check_eq("lat_valid", o_mem_valid, 1);
            if (done_seen) begin
                check_eq("idle_busy", o_busy, 0);
                check_eq("idle_done", o_done, 0);
                check_eq("idle_valid", o_mem_valid, 0);
                check_eq("idle_ram_en", o_ram_en, 0);
                fin = 1;
            end else begin
                if (o_busy) busy_cyc++;
                if (o_done) begin
                    dones++;
                    done_seen = 1;
                    check_eq("done_after_words", k, N);
                end
                if (o_ram_en) begin
                    check_eq("ram_offset", o_ram_offset, k % N);
                    check_eq("ram_index", o_ram_index, idx);
                    check_eq("ram_en_excl", o_mem_valid, 0);
                end
                if (held) begin
                    check_eq("hold_valid", o_mem_valid, 1);
                    check_eq("hold_addr", o_mem_addr, p_addr);
                    check_eq("hold_data", o_mem_data, p_data);
                    check_eq("hold_last", o_mem_last, p_last);
                end
                held = 0;
                if (o_mem_valid) begin
                    e_addr = {tag, idx, OW'(k), 2'b00};
                    e_data = ram_mem[way][k % N];
                    check_eq("mem_addr", o_mem_addr, e_addr);
                    check_eq("mem_data", o_mem_data, e_data);
                    check_eq("mem_last", o_mem_last, k == N - 1);
`ifdef DCACHE_EVICT_PARITY_EN
                    check_eq("mem_par", o_mem_par, ^e_data);
`endif
                    if (k == rst_word) begin
                        i_rst = 1'b1;
                        @(negedge i_clk);
                        check_zero_outputs("rst_mid");
                        i_rst = 1'b0;
                        i_mem_ready = 1'b1;
                        return;
                    end
                    if (k == stall_word && forced < stall_len) begin
                        i_mem_ready = 1'b0;
                        forced++;
                    end else if (rand_ready && $urandom_range(0, 2) == 0) begin
                        i_mem_ready = 1'b0;
                    end else begin
                        i_mem_ready = 1'b1;
                    end
                    if (!i_mem_ready) stalls++;
                    held   = !i_mem_ready;
                    p_addr = o_mem_addr;
                    p_data = o_mem_data;
                    p_last = o_mem_last;
                    if (k == pulse_word && !pulsed) begin
                        // Stray start while in SEND; must be dropped.
                        i_start    = 1'b1;
                        i_ev_tag   = ~tag;
                        i_ev_index = ~idx;
                        i_ev_way   = ~way;
                        pulsed     = 1;
                    end
                    if (i_mem_ready) k++;
                end else begin
                    i_mem_ready = 1'($urandom);
                end
            end
        end
        if (!fin) check_eq("timeout", 0, 1);
        check_eq("done_count", dones, 1);
        check_eq("words_sent", k, N);
        check_eq("busy_cycles", busy_cyc, 2 * N + 1 + stalls);
        i_mem_ready = 1'b1;
    endtask

    initial begin
        for (int w = 0; w < 4; w++) begin
            for (int o = 0; o < N; o++) ram_mem[w][o] = '0;
        end
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        check_zero_outputs("reset");
        i_rst = 1'b0;

        // Directed: nominal line, ready always high.
        do_line(20'h12345, IW'(3), 2'd2, -1, 0, 0, -1, -1);
        // Ready low for 3 cycles on word 1.
        do_line(20'h0BEEF, IW'(5), 2'd1, 1, 3, 0, -1, -1);
        // Stray start during SEND of word 3.
        do_line(20'h54321, IW'(7), 2'd3, -1, 0, 0, 3 % N, -1);
        // Reset mid-SEND of word 2, then a clean restart from offset 0.
        do_line(20'hABCDE, IW'(9), 2'd0, -1, 0, 0, -1, 2 % N);
        do_line(20'h13579, IW'(9), 2'd0, -1, 0, 0, -1, -1);
        // Each way, random tag/index and random stalls.
        for (int w = 0; w < 4; w++) begin
            do_line(TW'($urandom), IW'($urandom), 2'(w), -1, 0, 1, -1, -1);
        end
        // Random mix.
        for (int i = 0; i < 6; i++) begin
            do_line(TW'($urandom), IW'($urandom), 2'($urandom),
                    $urandom_range(0, N - 1), $urandom_range(0, 4), 1,
                    $urandom_range(0, N - 1), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_evict.md
# dcache_evict

Line-eviction reader for the 4-way data cache. On a start request it walks every word of one cache line through the data RAM's combinational read port, selects the victim way, and streams the words with their byte addresses to the memory-side write channel under a valid/ready handshake. It sits between the cache controller (victim selection) and the data RAM / memory write path, and is the read-side counterpart of the line-fill write path into the data RAM.

## Interface
- `dw`, 32, data word width; must match the data RAM.
- `iw`, `` `D_INDEX_WIDTH ``, set-index width.
- `ow`, `` `D_WO_WIDTH ``, word-offset width; the line holds 2^ow words.
- `tw`, 20, tag width; `mem_addr` is tw+iw+ow+2 bits.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request eviction; sampled only in IDLE.
- `ev_tag`  in  tw  victim tag; captured on accepted start.
- `ev_index`  in  iw  victim set; captured on accepted start.
- `ev_way`  in  2  victim way; captured on accepted start.
- `busy`  out  1  high from the cycle after accepted start until done.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `ram_index`  out  iw  data RAM index (latched index).
- `ram_offset`  out  ow  data RAM word offset (word counter).
- `ram_en`  out  1  data RAM enable; high only in READ.
- `ram_dout0`..`ram_dout3`  in  dw each  data RAM read data, ways 0-3.
- `mem_valid`  out  1  word valid to memory.
- `mem_ready`  in  1  memory accepts the word.
- `mem_addr`  out  tw+iw+ow+2  byte address {tag,index,offset,2'b00}.
- `mem_data`  out  dw  word data.
- `mem_last`  out  1  high with the final word of the line.

## Operation
- State machine IDLE, READ, SEND, DONE.
- IDLE: if `start`, latch tag/index/way, clear the word counter, and go to READ. Otherwise stay.
- READ: drive `ram_en`=1, `ram_index`, and `ram_offset`=counter. At posedge, capture `ram_dout[way]` into the data register, then go to SEND.
- SEND: `mem_valid`=1 with registered data, address, and `mem_last`=(counter==2^ow-1). On `mem_valid & mem_ready`:
  - if last, go to DONE;
  - else increment the counter and go to READ.
- DONE: `done`=1 for one cycle, then IDLE. `busy` is high in READ, SEND, and DONE.
- `mem_data`, `mem_addr`, and `mem_last` are stable while `mem_valid` is high and `mem_ready` is low. `mem_valid` never drops without a handshake.
- `start` outside IDLE is ignored, with no queuing.
- The counter is ow bits wide and its last value is all ones. It does not wrap within a line.
- Reset in any state: return to IDLE. The counter and data/address registers clear.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_en`=0, `ram_index`=0, `ram_offset`=0, `mem_valid`=0, `mem_addr`=0, `mem_data`=0, `mem_last`=0.
- Start accepted at edge T: READ in T+1, and the first `mem_valid` in T+2.
- Each word costs 1 READ cycle plus at least 1 SEND cycle. With `mem_ready` held high, a line takes 2·2^ow cycles plus 1 DONE cycle.
- RAM data is taken combinationally in READ and registered at that cycle's posedge. The RAM's negedge write port must not write the line being evicted while `busy` is high; this is the controller's responsibility.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_ready` to any output.

## Configuration
- `DCACHE_EVICT_PARITY_EN` defined: adds output `mem_par` (1 bit) = even parity (XOR) of `mem_data`. It is registered with the data, valid under the same handshake, and 0 on reset.
- Not defined: no `mem_par` port and no parity logic. Behaviour is otherwise identical.

## Test plan
- Reset, then `start` with tag 0x12345, index 3, way 2, and `mem_ready` tied 1 → words `ram_dout2` at offsets 0..N-1, addresses {0x12345,3,k,00}, `mem_last` only on k=N-1, `done` one cycle later, total 2N+1 cycles busy.
- `mem_ready` low for 3 cycles on word 1 → `mem_valid`, `mem_data`, and `mem_addr` held unchanged; the counter advances only after the handshake.
- `start` pulsed during SEND → ignored; the line completes once and exactly one `done` is produced.
- `rst` asserted mid-SEND of word 2 → next cycle IDLE with all outputs 0; a new `start` restarts from offset 0.
- Each way 0-3 with distinct preset RAM patterns (0xA0.., 0xB0.., 0xC0.., 0xD0..) → only the selected way's data appears.
- With `DCACHE_EVICT_PARITY_EN`: data 0x00000001 → `mem_par`=1; data 0x00000003 → `mem_par`=0.
